pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined CPU.
- Tracks destination registers of every in-flight instruction past decode in a shift-register scoreboard.
- Selects forwarded operand values for the instruction in decode, and raises a load-use stall when a load result is not yet available.
- Sits beside the decode stage. The execute, memory and writeback stages feed their current result values back into it.

Parameters:
- DW, 32, datapath width of forwarded values.
- RAW, 5, register address width.
- DEPTH, 3, number of tracked in-flight stages after decode (entry 0 = execute, entry DEPTH-1 = oldest); legal range 2..8.
- LOAD_STAGE, 2, lowest entry index at which a load result is valid in stage_data; legal range 1..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  RAW  source A register.
- id_rt  in  RAW  source B register.
- id_rs_used  in  1  source A is read.
- id_rt_used  in  1  source B is read.
- id_rd  in  RAW  destination register.
- id_wen  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  invalidate all tracked entries at the next edge.
- stage_data  in  DEPTH*DW  result currently produced by entry k, at bits [k*DW +: DW].
- stall  out  1  hold fetch/decode; insert a bubble into execute.
- fwd_a_sel  out  1  use fwd_a_data instead of the register file for source A.
- fwd_a_data  out  DW  forwarded value for source A.
- fwd_b_sel  out  1  use fwd_b_data instead of the register file for source B.
- fwd_b_data  out  DW  forwarded value for source B.
- stall_cnt  out  32  saturating count of stall cycles.

Behaviour:
- Scoreboard: DEPTH entries, each holding {v, rd, ld}.
- On every rising edge: entry k+1 <= entry k for k = 0..DEPTH-2, and the old entry DEPTH-1 is discarded. Downstream stages never stall.
- Entry 0 loading:
  - stall=0: entry 0 <= {id_valid & id_wen & (id_rd!=0), id_rd, id_is_load}.
  - stall=1: entry 0 <= bubble {0, 0, 0}.
- Match for source A: the youngest entry k (lowest index) with v=1, rd==id_rs and id_rs_used=1. Register 0 never matches. Source B uses the same rule with id_rt.
- Forwarding is combinational with zero latency.
  - Match found, not blocked: fwd_x_sel=1 and fwd_x_data=stage_data[k].
  - No match: fwd_x_sel=0 and fwd_x_data=0.
- Load-use stall: stall=1 when id_valid=1 and either source's youngest match has ld=1 with k < LOAD_STAGE.
  - When stalled, that source's fwd_x_sel=0.
  - An older matching entry never overrides a younger blocking load.
- stall is combinational from the scoreboard and the id_* inputs. It never depends on stage_data.
- flush=1 at an edge: all entries become invalid, overriding both shift and insertion. stall_cnt still counts that cycle if stall=1.
- stall_cnt increments on each edge where stall=1 and saturates at 0xFFFFFFFF.
- Reset (rst high, asynchronous): all entries cleared to {0,0,0} and stall_cnt=0. The combinational outputs therefore read stall=0, fwd_a_sel=fwd_b_sel=0, fwd_a_data=fwd_b_data=0 while rst is held.
- Reset asserted mid-stall clears the stall immediately; no partial state survives.
- Both sources may match different entries, or the same entry, in the same cycle.
- id_valid=0 forces stall=0; forwarding outputs still evaluate.

Test Plan:
- Back-to-back ALU hazard: decode "add r3" (wen) next cycle, then instruction reading r3 as rs with stage_data[0]=0x1234 -> fwd_a_sel=1, fwd_a_data=0x1234, stall=0.
- Load-use, DEPTH=3, LOAD_STAGE=2: "lw r5" issued, next cycle reader of r5 as rt -> stall=1 for 2 cycles; once the load reaches entry 2 with stage_data[2]=0xCAFE, fwd_b_data=0xCAFE, stall=0; stall_cnt=2.
- Youngest-wins: r7 written by entry 2 (0x1) and entry 0 (0x2); read r7 on both rs and rt -> both selects 1, both data 0x2.
- r0 and unused source: entry 0 writes r0, reader rs=0; separately rt=r4 matches entry 0 with id_rt_used=0 -> both selects 0, stall=0.
- Flush: three valid writers of r1 in flight, flush=1 for one edge, then reader of r1 -> fwd_a_sel=0, stall=0.
- Async reset mid-stall, plus saturation: assert rst between edges during a load-use stall -> stall=0 and stall_cnt=0 immediately. Force the count to 0xFFFFFFFE and stall 3 cycles -> stall_cnt holds 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_if
//
// Purpose:
//   Bundles the signals that pass between the decode stage (plus the result
//   feedback from the downstream stages) and the hazard/forwarding unit.
//   Clock and reset stay outside the bundle as plain ports.
//
// Parameters:
//   DW    - width of forwarded result values
//   RAW   - register address width
//   DEPTH - number of tracked in-flight stages after decode
//
// Signals (direction given from the hazard unit's point of view):
//   id_valid    in   decode holds a real instruction
//   id_rs       in   source A register
//   id_rt       in   source B register
//   id_rs_used  in   source A is read
//   id_rt_used  in   source B is read
//   id_rd       in   destination register
//   id_wen      in   instruction writes id_rd
//   id_is_load  in   instruction is a load
//   flush       in   invalidate every tracked entry at the next edge
//   stage_data  in   result of entry k at bits [k*DW +: DW]
//   stall       out  hold fetch/decode, bubble into execute
//   fwd_a_sel   out  use fwd_a_data for source A
//   fwd_a_data  out  forwarded value for source A
//   fwd_b_sel   out  use fwd_b_data for source B
//   fwd_b_data  out  forwarded value for source B
//   stall_cnt   out  saturating count of stall cycles
//
// Modports:
//   master - the pipeline side (drives decode info and stage results)
//   slave  - the hazard unit itself
// ---------------------------------------------------------------------------
interface pipe_hazard_unit_if #(
  parameter int DW    = 32,
  parameter int RAW   = 5,
  parameter int DEPTH = 3
);

  logic                  id_valid;
  logic [RAW-1:0]        id_rs;
  logic [RAW-1:0]        id_rt;
  logic                  id_rs_used;
  logic                  id_rt_used;
  logic [RAW-1:0]        id_rd;
  logic                  id_wen;
  logic                  id_is_load;
  logic                  flush;
  logic [DEPTH*DW-1:0]   stage_data;

  logic                  stall;
  logic                  fwd_a_sel;
  logic [DW-1:0]         fwd_a_data;
  logic                  fwd_b_sel;
  logic [DW-1:0]         fwd_b_data;
  logic [31:0]           stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_wen, id_is_load, flush, stage_data,
    input  stall, fwd_a_sel, fwd_a_data, fwd_b_sel, fwd_b_data, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_wen, id_is_load, flush, stage_data,
    output stall, fwd_a_sel, fwd_a_data, fwd_b_sel, fwd_b_data, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Purpose:
//   Hazard and forwarding controller that sits beside the decode stage of
//   the pipelined CPU. It keeps a shift-register scoreboard of the
//   destination registers of every instruction past decode, picks the
//   forwarded operand values for the instruction currently in decode, and
//   raises a load-use stall when a needed load result is not yet available.
//
// Parameters:
//   DW         - datapath width of forwarded values
//   RAW        - register address width
//   DEPTH      - tracked stages after decode (entry 0 = execute,
//                entry DEPTH-1 = oldest), 2..8
//   LOAD_STAGE - lowest entry index at which a load result is present in
//                stage_data, 1..DEPTH-1
//
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   hz  - slave side of pipe_hazard_unit_if (decode info, stage results,
//         stall/forwarding outputs and the stall counter)
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int DW         = 32,
  parameter int RAW        = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_unit_if.slave   hz
);

  // Catch illegal configurations at elaboration time.
  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_hazard_unit: DEPTH must be in 2..8");
  end
  if (LOAD_STAGE < 1 || LOAD_STAGE > DEPTH - 1) begin : g_bad_load_stage
    $error("pipe_hazard_unit: LOAD_STAGE must be in 1..DEPTH-1");
  end

  // One scoreboard slot per in-flight stage.
  typedef struct packed {
    logic           v;
    logic [RAW-1:0] rd;
    logic           ld;
  } sb_entry_t;

  sb_entry_t   sb_q [DEPTH];
  logic [31:0] stall_cnt_q;

  // Per-source match results.
  logic          a_hit;
  logic          a_ld;
  logic          a_early;
  logic [DW-1:0] a_data;
  logic          b_hit;
  logic          b_ld;
  logic          b_early;
  logic [DW-1:0] b_data;

  logic          a_blk;
  logic          b_blk;
  logic          stall;

  // Youngest-match search. Walking from the oldest entry towards entry 0
  // lets the youngest hit overwrite any older one, so an older matching
  // entry can never hide a younger in-flight load. Register 0 and unused
  // sources never match.
  always_comb begin
    a_hit   = 1'b0;
    a_ld    = 1'b0;
    a_early = 1'b0;
    a_data  = '0;
    b_hit   = 1'b0;
    b_ld    = 1'b0;
    b_early = 1'b0;
    b_data  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb_q[k].v && hz.id_rs_used && (hz.id_rs != '0) &&
          (sb_q[k].rd == hz.id_rs)) begin
        a_hit   = 1'b1;
        a_ld    = sb_q[k].ld;
        a_early = (k < LOAD_STAGE);
        a_data  = hz.stage_data[k*DW +: DW];
      end
      if (sb_q[k].v && hz.id_rt_used && (hz.id_rt != '0) &&
          (sb_q[k].rd == hz.id_rt)) begin
        b_hit   = 1'b1;
        b_ld    = sb_q[k].ld;
        b_early = (k < LOAD_STAGE);
        b_data  = hz.stage_data[k*DW +: DW];
      end
    end
  end

  // A source is blocked when its youngest producer is a load that has not
  // yet reached the stage where its data exists. Only a real decode
  // instruction can block; stall never looks at stage_data.
  assign a_blk = hz.id_valid & a_hit & a_ld & a_early;
  assign b_blk = hz.id_valid & b_hit & b_ld & b_early;
  assign stall = a_blk | b_blk;

  // Forwarding outputs; a blocked or unmatched source reads the register
  // file and its data bus is held at zero.
  always_comb begin
    hz.fwd_a_sel  = a_hit & ~a_blk;
    hz.fwd_a_data = (a_hit & ~a_blk) ? a_data : '0;
    hz.fwd_b_sel  = b_hit & ~b_blk;
    hz.fwd_b_data = (b_hit & ~b_blk) ? b_data : '0;
  end

  assign hz.stall     = stall;
  assign hz.stall_cnt = stall_cnt_q;

  // Scoreboard shift and stall counter. Downstream stages never stall, so
  // the scoreboard advances every cycle; a stall only replaces the entering
  // instruction with a bubble. Flush wins over both shift and insertion but
  // does not stop a stall in the same cycle from being counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      if (hz.flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          sb_q[k] <= '0;
        end
      end else begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          sb_q[k] <= sb_q[k-1];
        end
        if (stall) begin
          sb_q[0] <= '0;
        end else begin
          sb_q[0] <= '{v:  hz.id_valid & hz.id_wen & (hz.id_rd != '0),
                       rd: hz.id_rd,
                       ld: hz.id_is_load};
        end
      end
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

endmodule
